imm_gen_stage: RTL and testbench
================================

# imm_gen_stage

Registered, parametrised immediate-generation stage for the RISC-V datapath. It decodes the immediate of all base formats (I/S/B/U/J) from a 32-bit instruction word, sign-extended to XLEN. It also classifies the format, flags unsupported opcodes and computes the pc-relative target. A valid/ready handshake with a one-entry skid buffer lets it sit between fetch and execute when the core is pipelined. It also keeps a saturating count of illegal instructions.

## Interface
- XLEN, 32: datapath width; 32 or 64 only.
- CNT_W, 16: illegal-instruction counter width.
- clk  in  1  clock; all state on rising edge.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  inst_code/in_pc valid.
- in_ready  out  1  stage can accept.
- inst_code  in  32  instruction word.
- in_pc  in  XLEN  pc of inst_code.
- out_valid  out  1  output fields valid.
- out_ready  in  1  consumer accepts.
- imm_out  out  XLEN  sign-extended immediate.
- fmt  out  3  0=I, 1=S, 2=B, 3=U, 4=J, 5=R (no imm), 7=illegal.
- illegal  out  1  fmt==7.
- target  out  XLEN  in_pc + imm_out, modulo 2^XLEN.
- clr_cnt  in  1  synchronous clear of ill_cnt.
- ill_cnt  out  CNT_W  saturating illegal count.

## Operation
- Decode uses the opcode in inst_code[6:0]. If inst_code[1:0] != 2'b11, the word is illegal.
- I-format opcodes: 0000011, 0010011, 1100111, 1110011, 0001111. When XLEN==64, 0011011 is also I-format.
  - imm = sext(inst[31:20]).
  - Shift-immediates get no special case.
- S-format opcode: 0100011. imm = sext({inst[31:25], inst[11:7]}).
- B-format opcode: 1100011. imm = sext({inst[31], inst[7], inst[30:25], inst[11:8], 1'b0}).
- U-format opcodes: 0110111, 0010111. imm = sext({inst[31:12], 12'b0}).
  - The sext applies when XLEN==64.
- J-format opcode: 1101111. imm = sext({inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}).
- R-format opcode: 0110011. When XLEN==64, 0111011 is also R-format. For R-format, imm = 0.
- Any other opcode: fmt=7, illegal=1, imm=0. target is still in_pc + 0.
- Sign extension replicates inst[31] up to bit XLEN-1.
- target uses an XLEN-bit add; carry out is discarded.
- Datapath: combinational decode feeds a main output register (M) backed by a skid register (S).
- in_ready = !S_valid. in_ready is driven by a register only, with no combinational path from out_ready.
- Accept = in_valid && in_ready. On each clock edge:
  - M empty, or M draining this cycle (out_valid && out_ready): load M from S if S_valid, else from the accepted input. If S loaded M and an input was also accepted, the input goes to S.
  - M held (out_valid && !out_ready) and input accepted: the input goes to S, and in_ready drops next cycle.
- Ordering is strictly FIFO. A transfer is never dropped or duplicated.
- Output fields stay stable while out_valid && !out_ready.
- ill_cnt increments on each output handshake with illegal=1 and saturates at all-ones.
- clr_cnt has priority over an increment in the same cycle; the result is 0.

## Timing
- Reset values:
  - out_valid=0, imm_out=0, fmt=0, illegal=0, target=0, ill_cnt=0.
  - S empty, so in_ready=1 during and after reset.
- Latency: an input accepted at edge N appears on the outputs after edge N (one cycle).
- Throughput: one per cycle while out_ready=1.
- Backpressure: at most 2 transfers are held (M+S). in_ready reasserts the cycle after S drains into M.
- Reset asserted mid-transfer clears M, S and ill_cnt immediately. In-flight data is discarded.
- Changing in_valid or inst_code while in_ready=0 has no effect.

## Test plan
- XLEN=32, out_ready=1: in_pc=0x0, inst 0x00003223 then 0x00130213 on back-to-back cycles.
  - Required response: fmt=1, imm=0x00000004; then fmt=0, imm=0x00000001.
  - out_valid is high for 2 consecutive cycles, 1 cycle after each input.
- XLEN=32: B/U/J decode.
  - 0xFE000EE3 with pc=0x100 -> fmt=2, imm=0xFFFFFFFC, target=0x000000FC.
  - 0x123452B7 -> fmt=3, imm=0x12345000.
  - 0x008000EF with pc=0x10 -> fmt=4, imm=8, target=0x18.
- Illegal instructions: 0x00000000, then 0x0000007F, both handshaked.
  - Required response: fmt=7, illegal=1, imm=0 for each; ill_cnt=2.
  - clr_cnt pulsed in the same cycle as a third illegal handshake -> ill_cnt=0.
  - CNT_W=2 with 5 illegal handshakes -> ill_cnt saturates at 3.
- Backpressure: stream 4 distinct instructions with out_ready=0 for 3 cycles, then 1.
  - in_ready falls after the 2nd accept.
  - Outputs appear in order with none lost, and fields are stable while stalled.
- XLEN=64: 0xFFF00093 -> imm=0xFFFFFFFFFFFFFFFF, fmt=0.
  - 0x0000003B -> fmt=5, imm=0.
- Reset asserted while M and S are both full -> out_valid=0 and in_ready=1 immediately, with no output after release.

Source files
------------

// File: rtl/imm_gen_stage_if.sv
// rtl/imm_gen_stage_if.sv - handshake and result bundle for the immediate-generation stage
interface imm_gen_stage_if #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      inst_code;
    logic [XLEN-1:0]  in_pc;
    logic             out_valid;
    logic             out_ready;
    logic [XLEN-1:0]  imm_out;
    logic [2:0]       fmt;
    logic             illegal;
    logic [XLEN-1:0]  target;
    logic             clr_cnt;
    logic [CNT_W-1:0] ill_cnt;

    modport master (
        output in_valid, inst_code, in_pc, out_ready, clr_cnt,
        input  in_ready, out_valid, imm_out, fmt, illegal, target, ill_cnt
    );

    modport slave (
        input  in_valid, inst_code, in_pc, out_ready, clr_cnt,
        output in_ready, out_valid, imm_out, fmt, illegal, target, ill_cnt
    );
endinterface

// File: rtl/imm_gen_stage.sv
// rtl/imm_gen_stage.sv - registered RISC-V immediate decode with skid buffer and illegal counter
module imm_gen_stage #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input  logic          clk,
    input  logic          reset,
    imm_gen_stage_if.slave bus
);
    localparam logic [2:0] FMT_I   = 3'd0;
    localparam logic [2:0] FMT_S   = 3'd1;
    localparam logic [2:0] FMT_B   = 3'd2;
    localparam logic [2:0] FMT_U   = 3'd3;
    localparam logic [2:0] FMT_J   = 3'd4;
    localparam logic [2:0] FMT_R   = 3'd5;
    localparam logic [2:0] FMT_ILL = 3'd7;

    logic [31:0]     inst;
    logic [XLEN-1:0] dec_imm;
    logic [XLEN-1:0] dec_tgt;
    logic [2:0]      dec_fmt;

    assign inst = bus.inst_code;

    // Size casts of signed slices do the sign extension up to XLEN.
    always_comb begin
        dec_fmt = FMT_ILL;
        dec_imm = '0;
        case (inst[6:0])
            7'b0000011, 7'b0010011, 7'b1100111, 7'b1110011, 7'b0001111: begin
                dec_fmt = FMT_I;
                dec_imm = XLEN'($signed(inst[31:20]));
            end
            7'b0011011: begin
                if (XLEN == 64) begin
                    dec_fmt = FMT_I;
                    dec_imm = XLEN'($signed(inst[31:20]));
                end
            end
            7'b0100011: begin
                dec_fmt = FMT_S;
                dec_imm = XLEN'($signed({inst[31:25], inst[11:7]}));
            end
            7'b1100011: begin
                dec_fmt = FMT_B;
                dec_imm = XLEN'($signed({inst[31], inst[7], inst[30:25], inst[11:8], 1'b0}));
            end
            7'b0110111, 7'b0010111: begin
                dec_fmt = FMT_U;
                dec_imm = XLEN'($signed({inst[31:12], 12'b0}));
            end
            7'b1101111: begin
                dec_fmt = FMT_J;
                dec_imm = XLEN'($signed({inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}));
            end
            7'b0110011: dec_fmt = FMT_R;
            7'b0111011: begin
                if (XLEN == 64) dec_fmt = FMT_R;
            end
            default: ;
        endcase
    end

    assign dec_tgt = bus.in_pc + dec_imm;

    logic             m_valid, s_valid;
    logic [XLEN-1:0]  m_imm, s_imm, m_tgt, s_tgt;
    logic [2:0]       m_fmt, s_fmt;
    logic [CNT_W-1:0] cnt;
    logic             accept, m_free;

    assign accept = bus.in_valid && !s_valid;
    assign m_free = !m_valid || bus.out_ready;

    // Accept is impossible while S is occupied, so S never loads while draining.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            m_valid <= 1'b0;
            m_imm   <= '0;
            m_tgt   <= '0;
            m_fmt   <= FMT_I;
            s_valid <= 1'b0;
            s_imm   <= '0;
            s_tgt   <= '0;
            s_fmt   <= FMT_I;
        end else if (m_free) begin
            if (s_valid) begin
                m_valid <= 1'b1;
                m_imm   <= s_imm;
                m_tgt   <= s_tgt;
                m_fmt   <= s_fmt;
                s_valid <= 1'b0;
            end else if (accept) begin
                m_valid <= 1'b1;
                m_imm   <= dec_imm;
                m_tgt   <= dec_tgt;
                m_fmt   <= dec_fmt;
            end else begin
                m_valid <= 1'b0;
            end
        end else if (accept) begin
            s_valid <= 1'b1;
            s_imm   <= dec_imm;
            s_tgt   <= dec_tgt;
            s_fmt   <= dec_fmt;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (bus.clr_cnt) begin
            cnt <= '0;
        end else if (m_valid && bus.out_ready && (m_fmt == FMT_ILL) && (cnt != {CNT_W{1'b1}})) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign bus.in_ready  = !s_valid;
    assign bus.out_valid = m_valid;
    assign bus.imm_out   = m_imm;
    assign bus.fmt       = m_fmt;
    assign bus.illegal   = (m_fmt == FMT_ILL);
    assign bus.target    = m_tgt;
    assign bus.ill_cnt   = cnt;
endmodule

// File: tb/tb_imm_gen_stage.sv
// tb/tb_imm_gen_stage.sv - directed-vector bench for imm_gen_stage at XLEN 32/64 and a narrow counter
module tb_imm_gen_stage;
    logic clk;
    logic reset;
    int   vecs;
    int   errs;

    imm_gen_stage_if #(.XLEN(32), .CNT_W(16)) if32 ();
    imm_gen_stage_if #(.XLEN(32), .CNT_W(2))  ifs ();
    imm_gen_stage_if #(.XLEN(64), .CNT_W(16)) if64 ();

    imm_gen_stage #(.XLEN(32), .CNT_W(16)) dut32 (.clk(clk), .reset(reset), .bus(if32.slave));
    imm_gen_stage #(.XLEN(32), .CNT_W(2))  dut_sat (.clk(clk), .reset(reset), .bus(ifs.slave));
    imm_gen_stage #(.XLEN(64), .CNT_W(16)) dut64 (.clk(clk), .reset(reset), .bus(if64.slave));

    // The narrow-counter instance mirrors the stimulus of the main instance.
    assign ifs.in_valid  = if32.in_valid;
    assign ifs.inst_code = if32.inst_code;
    assign ifs.in_pc     = if32.in_pc;
    assign ifs.out_ready = if32.out_ready;
    assign ifs.clr_cnt   = if32.clr_cnt;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        if32.in_valid = 0; if32.inst_code = 0; if32.in_pc = 0; if32.out_ready = 1; if32.clr_cnt = 0;
        if64.in_valid = 0; if64.inst_code = 0; if64.in_pc = 0; if64.out_ready = 1; if64.clr_cnt = 0;
        tick();
        tick();
        vecs++;
        if (if32.in_ready !== 1'b1 || if32.out_valid !== 1'b0) begin
            errs++; $display("FAIL reset_hs: in_ready=%b out_valid=%b want 1 0", if32.in_ready, if32.out_valid);
        end
        vecs++;
        if (if32.imm_out !== 32'h0 || if32.fmt !== 3'd0 || if32.illegal !== 1'b0 || if32.target !== 32'h0) begin
            errs++; $display("FAIL reset_fields: imm=%h fmt=%0d ill=%b tgt=%h want 0", if32.imm_out, if32.fmt, if32.illegal, if32.target);
        end
        vecs++;
        if (if32.ill_cnt !== 16'h0 || if64.out_valid !== 1'b0 || if64.in_ready !== 1'b1) begin
            errs++; $display("FAIL reset_cnt: cnt=%0d ov64=%b ir64=%b want 0 0 1", if32.ill_cnt, if64.out_valid, if64.in_ready);
        end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_back_to_back();
        if32.in_pc = 32'h0;
        if32.in_valid = 1; if32.inst_code = 32'h00003223;
        tick();
        vecs++;
        if (if32.out_valid !== 1'b1 || if32.fmt !== 3'd1 || if32.imm_out !== 32'h4 || if32.target !== 32'h4) begin
            errs++; $display("FAIL b2b_s: ov=%b fmt=%0d imm=%h tgt=%h want 1 1 4 4", if32.out_valid, if32.fmt, if32.imm_out, if32.target);
        end
        if32.inst_code = 32'h00130213;
        tick();
        vecs++;
        if (if32.out_valid !== 1'b1 || if32.fmt !== 3'd0 || if32.imm_out !== 32'h1 || if32.target !== 32'h1) begin
            errs++; $display("FAIL b2b_i: ov=%b fmt=%0d imm=%h tgt=%h want 1 0 1 1", if32.out_valid, if32.fmt, if32.imm_out, if32.target);
        end
        if32.in_valid = 0;
        tick();
        vecs++;
        if (if32.out_valid !== 1'b0) begin
            errs++; $display("FAIL b2b_idle: out_valid=%b want 0", if32.out_valid);
        end
    endtask

    task automatic test_decode_bju();
        logic [31:0] t_inst [5];
        logic [31:0] t_pc   [5];
        logic [2:0]  t_fmt  [5];
        logic [31:0] t_imm  [5];
        logic [31:0] t_tgt  [5];
        t_inst = '{32'hFE000EE3, 32'h123452B7, 32'h008000EF, 32'h0000003B, 32'h00000033};
        t_pc   = '{32'h100,      32'h0,        32'h10,       32'h40,       32'h8};
        t_fmt  = '{3'd2,         3'd3,         3'd4,         3'd7,         3'd5};
        t_imm  = '{32'hFFFFFFFC, 32'h12345000, 32'h8,        32'h0,        32'h0};
        t_tgt  = '{32'hFC,       32'h12345000, 32'h18,       32'h40,       32'h8};
        for (int i = 0; i < 5; i++) begin
            if32.in_valid = 1; if32.inst_code = t_inst[i]; if32.in_pc = t_pc[i];
            tick();
            vecs++;
            if (if32.out_valid !== 1'b1 || if32.fmt !== t_fmt[i] || if32.imm_out !== t_imm[i] || if32.target !== t_tgt[i]) begin
                errs++; $display("FAIL decode[%0d] %h: ov=%b fmt=%0d imm=%h tgt=%h want 1 %0d %h %h",
                                 i, t_inst[i], if32.out_valid, if32.fmt, if32.imm_out, if32.target, t_fmt[i], t_imm[i], t_tgt[i]);
            end
            if32.in_valid = 0;
            tick();
        end
    endtask

    task automatic test_illegal();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        if32.out_ready = 1; if32.in_pc = 32'h20;
        if32.in_valid = 1; if32.inst_code = 32'h00000000;
        tick();
        vecs++;
        if (if32.fmt !== 3'd7 || if32.illegal !== 1'b1 || if32.imm_out !== 32'h0 || if32.target !== 32'h20) begin
            errs++; $display("FAIL ill_zero: fmt=%0d ill=%b imm=%h tgt=%h want 7 1 0 20", if32.fmt, if32.illegal, if32.imm_out, if32.target);
        end
        if32.inst_code = 32'h0000007F;
        tick();
        vecs++;
        if (if32.fmt !== 3'd7 || if32.illegal !== 1'b1 || if32.imm_out !== 32'h0 || if32.ill_cnt !== 16'd1) begin
            errs++; $display("FAIL ill_7f: fmt=%0d ill=%b imm=%h cnt=%0d want 7 1 0 1", if32.fmt, if32.illegal, if32.imm_out, if32.ill_cnt);
        end
        if32.in_valid = 0;
        tick();
        vecs++;
        if (if32.ill_cnt !== 16'd2 || ifs.ill_cnt !== 2'd2) begin
            errs++; $display("FAIL ill_cnt2: cnt=%0d sat=%0d want 2 2", if32.ill_cnt, ifs.ill_cnt);
        end
        if32.in_valid = 1; if32.inst_code = 32'h00000000;
        tick();
        if32.in_valid = 0; if32.clr_cnt = 1;
        tick();
        if32.clr_cnt = 0;
        vecs++;
        if (if32.ill_cnt !== 16'd0 || ifs.ill_cnt !== 2'd0) begin
            errs++; $display("FAIL ill_clr: cnt=%0d sat=%0d want 0 0", if32.ill_cnt, ifs.ill_cnt);
        end
        if32.in_valid = 1;
        repeat (5) tick();
        if32.in_valid = 0;
        tick();
        vecs++;
        if (if32.ill_cnt !== 16'd5 || ifs.ill_cnt !== 2'd3) begin
            errs++; $display("FAIL ill_sat: cnt=%0d sat=%0d want 5 3", if32.ill_cnt, ifs.ill_cnt);
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] insts [5];
        int          s_idx [7];
        logic        s_v   [7];
        logic        s_or  [7];
        logic        e_ov  [7];
        logic [31:0] e_imm [7];
        logic        e_ir  [7];
        // Index 4 is a junk word offered while in_ready is low; it must never appear.
        insts = '{32'h00100013, 32'h00200013, 32'h00300013, 32'h00400013, 32'h0000007F};
        s_idx = '{0, 1, 4, 2, 2, 3, 0};
        s_v   = '{1, 1, 1, 1, 1, 1, 0};
        s_or  = '{0, 0, 0, 1, 1, 1, 1};
        e_ov  = '{1, 1, 1, 1, 1, 1, 0};
        e_imm = '{32'h1, 32'h1, 32'h1, 32'h2, 32'h3, 32'h4, 32'h0};
        e_ir  = '{1, 0, 0, 1, 1, 1, 1};
        if32.in_pc = 32'h0;
        for (int k = 0; k < 7; k++) begin
            if32.in_valid = s_v[k]; if32.inst_code = insts[s_idx[k]]; if32.out_ready = s_or[k];
            tick();
            vecs++;
            if (if32.out_valid !== e_ov[k] || if32.in_ready !== e_ir[k] ||
                (e_ov[k] && (if32.imm_out !== e_imm[k] || if32.target !== e_imm[k] || if32.fmt !== 3'd0))) begin
                errs++; $display("FAIL bp[%0d]: ov=%b ir=%b imm=%h tgt=%h fmt=%0d want %b %b %h %h 0",
                                 k, if32.out_valid, if32.in_ready, if32.imm_out, if32.target, if32.fmt, e_ov[k], e_ir[k], e_imm[k], e_imm[k]);
            end
        end
        if32.out_ready = 1;
    endtask

    task automatic test_xlen64();
        if64.in_valid = 1; if64.inst_code = 32'hFFF00093; if64.in_pc = 64'h1000;
        tick();
        vecs++;
        if (if64.out_valid !== 1'b1 || if64.fmt !== 3'd0 || if64.imm_out !== 64'hFFFFFFFFFFFFFFFF || if64.target !== 64'hFFF) begin
            errs++; $display("FAIL x64_i: ov=%b fmt=%0d imm=%h tgt=%h", if64.out_valid, if64.fmt, if64.imm_out, if64.target);
        end
        if64.inst_code = 32'h0000003B;
        tick();
        vecs++;
        if (if64.fmt !== 3'd5 || if64.imm_out !== 64'h0 || if64.illegal !== 1'b0 || if64.target !== 64'h1000) begin
            errs++; $display("FAIL x64_r: fmt=%0d imm=%h ill=%b tgt=%h want 5 0 0 1000", if64.fmt, if64.imm_out, if64.illegal, if64.target);
        end
        if64.inst_code = 32'h8000001B;
        tick();
        vecs++;
        if (if64.fmt !== 3'd0 || if64.imm_out !== 64'hFFFFFFFFFFFFF800) begin
            errs++; $display("FAIL x64_addiw: fmt=%0d imm=%h want 0 fffffffffffff800", if64.fmt, if64.imm_out);
        end
        if64.inst_code = 32'h800002B7;
        tick();
        vecs++;
        if (if64.fmt !== 3'd3 || if64.imm_out !== 64'hFFFFFFFF80000000) begin
            errs++; $display("FAIL x64_lui: fmt=%0d imm=%h want 3 ffffffff80000000", if64.fmt, if64.imm_out);
        end
        if64.in_valid = 0;
        tick();
    endtask

    task automatic test_reset_midflight();
        if32.out_ready = 0; if32.in_pc = 32'h0;
        if32.in_valid = 1; if32.inst_code = 32'h00100013;
        tick();
        if32.inst_code = 32'h00200013;
        tick();
        if32.in_valid = 0;
        vecs++;
        if (if32.in_ready !== 1'b0 || if32.out_valid !== 1'b1) begin
            errs++; $display("FAIL mid_full: ir=%b ov=%b want 0 1", if32.in_ready, if32.out_valid);
        end
        reset = 1'b1;
        #1;
        vecs++;
        if (if32.out_valid !== 1'b0 || if32.in_ready !== 1'b1 || if32.ill_cnt !== 16'd0) begin
            errs++; $display("FAIL mid_reset: ov=%b ir=%b cnt=%0d want 0 1 0", if32.out_valid, if32.in_ready, if32.ill_cnt);
        end
        tick();
        reset = 1'b0;
        if32.out_ready = 1;
        for (int k = 0; k < 3; k++) begin
            tick();
            vecs++;
            if (if32.out_valid !== 1'b0 || if32.in_ready !== 1'b1) begin
                errs++; $display("FAIL mid_after[%0d]: ov=%b ir=%b want 0 1", k, if32.out_valid, if32.in_ready);
            end
        end
    endtask

    initial begin
        vecs = 0;
        errs = 0;
        test_reset();
        test_back_to_back();
        test_decode_bju();
        test_illegal();
        test_backpressure();
        test_xlen64();
        test_reset_midflight();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
